// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap sequencer: sequencer states,
// interrupt cause codes, the mcause interrupt flag position and helpers that
// build the mcause value and the trap handler address.
package trap_ctrl_pkg;

    // Sequencer states; IDLE is the only state that samples requests
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SAVE_EPC   = 3'd1,
        SAVE_CAUSE = 3'd2,
        JUMP       = 3'd3,
        RET        = 3'd4
    } trap_state_e;

    // Interrupt cause codes reported in mcause
    localparam logic [3:0] CAUSE_IRQ_EXT   = 4'd11;
    localparam logic [3:0] CAUSE_IRQ_TIMER = 4'd7;

    // Bit of mcause that distinguishes interrupts from exceptions
    localparam int IRQ_FLAG_BIT = 31;

    // mtvec[1:0] value selecting vectored interrupt dispatch
    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    // Assemble the 32-bit mcause value: interrupt flag on top, code at the bottom
    function automatic logic [31:0] makeCause(input logic isIrq, input logic [3:0] code);
        logic [31:0] cause;
        cause               = '0;
        cause[3:0]          = code;
        cause[IRQ_FLAG_BIT] = isIrq;
        return cause;
    endfunction

    // Handler address: mtvec base with the mode bits cleared; interrupts in
    // vectored mode land on base + 4*code
    function automatic logic [31:0] trapTarget(input logic [31:0] mtvec,
                                               input logic        isIrq,
                                               input logic [3:0]  code,
                                               input logic        vectoredEn);
        logic [31:0] base;
        base = {mtvec[31:2], 2'b00};
        if (vectoredEn && (mtvec[1:0] == MTVEC_MODE_VECTORED) && isIrq) begin
            return base + {26'd0, code, 2'b00};
        end
        return base;
    endfunction

endpackage

// File: rtl/trap_ctrl_irq_prio.sv
// Combinational request qualifier and priority encoder for the trap
// sequencer. Exceptions beat interrupts, external beats timer, and mret is
// only taken when no trap wants the core. Interrupts are masked by MIE.
module irq_prio
    import trap_ctrl_pkg::*;
(
    input  logic       excReq,
    input  logic [3:0] excCause,
    input  logic       irqExt,
    input  logic       irqTimer,
    input  logic       mret,
    input  logic       mie,
    output logic       accept,
    output logic       isIrq,
    output logic [3:0] code,
    output logic       isMret
);

    // Pick the highest-priority qualified request and report its cause code
    always_comb begin
        accept = 1'b0;
        isIrq  = 1'b0;
        code   = 4'd0;
        isMret = 1'b0;
        if (excReq) begin
            accept = 1'b1;
            code   = excCause;
        end else if (irqExt && mie) begin
            accept = 1'b1;
            isIrq  = 1'b1;
            code   = CAUSE_IRQ_EXT;
        end else if (irqTimer && mie) begin
            accept = 1'b1;
            isIrq  = 1'b1;
            code   = CAUSE_IRQ_TIMER;
        end else if (mret) begin
            isMret = 1'b1;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer. On a trap it saves the PC into mepc, then the
// cause into mcause, then redirects to the handler, one step per cycle while
// holding the pipeline stalled. On mret it jumps to mepc and restores MIE.
// It owns mstatus.MIE / MPIE and exposes them to the CSR read mux.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        excReq,
    input  logic [3:0]  excCause,
    input  logic        irqExt,
    input  logic        irqTimer,
    input  logic        mret,
    input  logic        mieWe,
    input  logic        mieDi,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic        mepcWe,
    output logic [31:0] mepcDi,
    output logic        mcauseWe,
    output logic [31:0] mcauseDi,
    output logic        mstatusMie,
    output logic        mstatusMpie,
    output logic        stall,
    output logic        flush,
    output logic        pcLoad,
    output logic [31:0] pcTarget
);

    trap_state_e state_q;
    logic        mie_q;
    logic        mpie_q;
    logic        causeIrq_q;
    logic [3:0]  causeCode_q;
    logic        mepcWe_q;
    logic [31:0] mepcDi_q;
    logic        mcauseWe_q;
    logic [31:0] mcauseDi_q;
    logic        pcLoad_q;
    logic [31:0] pcTarget_q;

    logic        prioAccept;
    logic        prioIsIrq;
    logic [3:0]  prioCode;
    logic        prioIsMret;
    logic        idleActive_d;
    logic        trapAccept_d;
    logic        mretAccept_d;

    irq_prio uPrio (
        .excReq   (excReq),
        .excCause (excCause),
        .irqExt   (irqExt),
        .irqTimer (irqTimer),
        .mret     (mret),
        .mie      (mie_q),
        .accept   (prioAccept),
        .isIrq    (prioIsIrq),
        .code     (prioCode),
        .isMret   (prioIsMret)
    );

    // Requests only count in IDLE; gating with reset keeps stall/flush low while reset is held
    always_comb begin
        idleActive_d = reset && (state_q == IDLE);
        trapAccept_d = idleActive_d && prioAccept;
        mretAccept_d = idleActive_d && prioIsMret;
    end

    // Sequencer with registered CSR strobes and PC redirect; data outputs are zero whenever their strobe is
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mie_q       <= 1'b0;
            mpie_q      <= 1'b0;
            causeIrq_q  <= 1'b0;
            causeCode_q <= 4'd0;
            mepcWe_q    <= 1'b0;
            mepcDi_q    <= '0;
            mcauseWe_q  <= 1'b0;
            mcauseDi_q  <= '0;
            pcLoad_q    <= 1'b0;
            pcTarget_q  <= '0;
        end else begin
            mepcWe_q   <= 1'b0;
            mepcDi_q   <= '0;
            mcauseWe_q <= 1'b0;
            mcauseDi_q <= '0;
            pcLoad_q   <= 1'b0;
            pcTarget_q <= '0;
            case (state_q)
                IDLE: begin
                    if (trapAccept_d) begin
                        state_q     <= SAVE_EPC;
                        causeIrq_q  <= prioIsIrq;
                        causeCode_q <= prioCode;
                        mpie_q      <= mie_q;
                        mie_q       <= 1'b0;
                        mepcWe_q    <= 1'b1;
                        mepcDi_q    <= pc;
                    end else if (mretAccept_d) begin
                        state_q    <= RET;
                        pcLoad_q   <= 1'b1;
                        pcTarget_q <= mepc;
                    end else if (mieWe) begin
                        mie_q <= mieDi;
                    end
                end
                SAVE_EPC: begin
                    state_q    <= SAVE_CAUSE;
                    mcauseWe_q <= 1'b1;
                    mcauseDi_q <= makeCause(causeIrq_q, causeCode_q);
                end
                SAVE_CAUSE: begin
                    state_q    <= JUMP;
                    pcLoad_q   <= 1'b1;
                    pcTarget_q <= trapTarget(mtvec, causeIrq_q, causeCode_q, VECTORED_EN);
                end
                JUMP: begin
                    state_q <= IDLE;
                end
                RET: begin
                    state_q <= IDLE;
                    mie_q   <= mpie_q;
                    mpie_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Drive the ports from the registered values plus the combinational accept-cycle stall/flush
    always_comb begin
        mepcWe      = mepcWe_q;
        mepcDi      = mepcDi_q;
        mcauseWe    = mcauseWe_q;
        mcauseDi    = mcauseDi_q;
        pcLoad      = pcLoad_q;
        pcTarget    = pcTarget_q;
        mstatusMie  = mie_q;
        mstatusMpie = mpie_q;
        flush       = trapAccept_d || mretAccept_d;
        stall       = (state_q != IDLE) || trapAccept_d || mretAccept_d;
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl. A transaction-level model predicts every
// output each cycle: an accepted request schedules the list of per-cycle CSR
// writes / redirects it must produce, and the MIE/MPIE bits follow the
// privileged-spec rules. Directed scenarios add literal checks on top.
module tb_trap_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        excReq;
    logic [3:0]  excCause;
    logic        irqExt;
    logic        irqTimer;
    logic        mret;
    logic        mieWe;
    logic        mieDi;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        mepcWe;
    logic [31:0] mepcDi;
    logic        mcauseWe;
    logic [31:0] mcauseDi;
    logic        mstatusMie;
    logic        mstatusMpie;
    logic        stall;
    logic        flush;
    logic        pcLoad;
    logic [31:0] pcTarget;

    int checkCount = 0;
    int errorCount = 0;

    trap_ctrl #(.VECTORED_EN(1'b1)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .excReq      (excReq),
        .excCause    (excCause),
        .irqExt      (irqExt),
        .irqTimer    (irqTimer),
        .mret        (mret),
        .mieWe       (mieWe),
        .mieDi       (mieDi),
        .mtvec       (mtvec),
        .mepc        (mepc),
        .mepcWe      (mepcWe),
        .mepcDi      (mepcDi),
        .mcauseWe    (mcauseWe),
        .mcauseDi    (mcauseDi),
        .mstatusMie  (mstatusMie),
        .mstatusMpie (mstatusMpie),
        .stall       (stall),
        .flush       (flush),
        .pcLoad      (pcLoad),
        .pcTarget    (pcTarget)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: scheduled per-cycle actions after an accept
    localparam int K_EPC   = 1;
    localparam int K_CAUSE = 2;
    localparam int K_JUMP  = 3;
    localparam int K_RET   = 4;

    typedef struct {
        int          kind;
        logic [31:0] data;
    } rec_t;

    rec_t sched[$];
    logic mMie  = 1'b0;
    logic mMpie = 1'b0;
    int   decision;

    // Values captured at the last check point, for directed checks
    logic        oStall, oFlush, oMepcWe, oMcauseWe, oPcLoad, oMie, oMpie;
    logic [31:0] oMepcDi, oMcauseDi, oPcTarget;

    // Compare one observed value with its expected value
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive the request inputs for the coming cycle
    task automatic applyStimulus(input logic exc, input logic [3:0] cause, input logic ext,
                                 input logic tim, input logic mr, input logic we, input logic di);
        excReq   = exc;
        excCause = cause;
        irqExt   = ext;
        irqTimer = tim;
        mret     = mr;
        mieWe    = we;
        mieDi    = di;
    endtask

    // Which request the model accepts from the current inputs (0 = none, 4 = mret)
    function automatic int decide();
        if (excReq)               return 1;
        if (irqExt && mMie)       return 2;
        if (irqTimer && mMie)     return 3;
        if (mret)                 return 4;
        return 0;
    endfunction

    // One clock: check all outputs mid-cycle against the model, then advance the model at the edge
    task automatic stepCycle();
        logic        eStall, eFlush, eMepcWe, eMcauseWe, ePcLoad;
        logic [31:0] eMepcDi, eMcauseDi, ePcTarget;
        rec_t        r;
        logic [3:0]  code;
        logic        irq;
        logic [31:0] causeVal;
        logic [31:0] target;
        @(negedge clk);
        eStall = 0; eFlush = 0; eMepcWe = 0; eMcauseWe = 0; ePcLoad = 0;
        eMepcDi = 0; eMcauseDi = 0; ePcTarget = 0;
        decision = 0;
        if (sched.size() > 0) begin
            eStall = 1;
            case (sched[0].kind)
                K_EPC:   begin eMepcWe = 1;   eMepcDi = sched[0].data;   end
                K_CAUSE: begin eMcauseWe = 1; eMcauseDi = sched[0].data; end
                default: begin ePcLoad = 1;   ePcTarget = sched[0].data; end
            endcase
        end else begin
            decision = decide();
            eStall = (decision != 0);
            eFlush = (decision != 0);
        end
        oStall = stall; oFlush = flush; oMepcWe = mepcWe; oMcauseWe = mcauseWe;
        oPcLoad = pcLoad; oMie = mstatusMie; oMpie = mstatusMpie;
        oMepcDi = mepcDi; oMcauseDi = mcauseDi; oPcTarget = pcTarget;
        checkOutput("stall", {31'd0, oStall}, {31'd0, eStall});
        checkOutput("flush", {31'd0, oFlush}, {31'd0, eFlush});
        checkOutput("mepcWe", {31'd0, oMepcWe}, {31'd0, eMepcWe});
        checkOutput("mepcDi", oMepcDi, eMepcDi);
        checkOutput("mcauseWe", {31'd0, oMcauseWe}, {31'd0, eMcauseWe});
        checkOutput("mcauseDi", oMcauseDi, eMcauseDi);
        checkOutput("pcLoad", {31'd0, oPcLoad}, {31'd0, ePcLoad});
        checkOutput("pcTarget", oPcTarget, ePcTarget);
        checkOutput("mstatusMie", {31'd0, oMie}, {31'd0, mMie});
        checkOutput("mstatusMpie", {31'd0, oMpie}, {31'd0, mMpie});
        @(posedge clk);
        if (sched.size() > 0) begin
            r = sched.pop_front();
            if (r.kind == K_RET) begin
                mMie  = mMpie;
                mMpie = 1'b1;
            end
        end else if (decision >= 1 && decision <= 3) begin
            irq      = (decision != 1);
            code     = (decision == 1) ? excCause : ((decision == 2) ? 4'd11 : 4'd7);
            causeVal = irq ? (32'h8000_0000 + 32'(code)) : 32'(code);
            target   = (mtvec & 32'hFFFF_FFFC);
            if (irq && mtvec[1:0] == 2'b01) target = target + 32'(code) * 4;
            sched.push_back('{K_EPC, pc});
            sched.push_back('{K_CAUSE, causeVal});
            sched.push_back('{K_JUMP, target});
            mMpie = mMie;
            mMie  = 1'b0;
        end else if (decision == 4) begin
            sched.push_back('{K_RET, mepc});
        end else if (mieWe) begin
            mMie = mieDi;
        end
        #1;
    endtask

    task automatic modelReset();
        sched.delete();
        mMie  = 1'b0;
        mMpie = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        pc = 0; mtvec = 0; mepc = 0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        #12;
        checkOutput("rst_stall", {31'd0, stall}, 32'd0);
        checkOutput("rst_mie", {31'd0, mstatusMie}, 32'd0);
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #1;

        // Exception at pc 0x100, handler at 0x200
        pc = 32'h100; mtvec = 32'h200;
        applyStimulus(1, 4'd2, 0, 0, 0, 0, 0);
        stepCycle();
        checkOutput("exc_flush", {31'd0, oFlush}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        stepCycle();
        checkOutput("exc_mepcDi", oMepcDi, 32'h100);
        stepCycle();
        checkOutput("exc_mcauseDi", oMcauseDi, 32'h2);
        stepCycle();
        checkOutput("exc_pcTarget", oPcTarget, 32'h200);
        checkOutput("exc_mie", {31'd0, oMie}, 32'd0);
        stepCycle();
        checkOutput("exc_idle", {31'd0, oStall}, 32'd0);

        // Vectored timer interrupt
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        stepCycle();
        mtvec = 32'h201; pc = 32'h40;
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        stepCycle();
        checkOutput("tmr_mepcDi", oMepcDi, 32'h40);
        stepCycle();
        checkOutput("tmr_mcauseDi", oMcauseDi, 32'h8000_0007);
        checkOutput("tmr_mpie", {31'd0, oMpie}, 32'd1);
        stepCycle();
        checkOutput("tmr_pcTarget", oPcTarget, 32'h21C);
        stepCycle();

        // Masked external interrupt, then unmasked
        mtvec = 32'h200;
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            checkOutput("mask_stall", {31'd0, oStall}, 32'd0);
            checkOutput("mask_we", {30'd0, oMepcWe, oMcauseWe}, 32'd0);
        end
        applyStimulus(0, 0, 1, 0, 0, 1, 1);
        stepCycle();
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        stepCycle();
        checkOutput("ext_flush", {31'd0, oFlush}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        stepCycle();
        stepCycle();
        checkOutput("ext_mcauseDi", oMcauseDi, 32'h8000_000B);
        stepCycle();
        checkOutput("ext_pcTarget", oPcTarget, 32'h200);
        stepCycle();

        // Simultaneous exception, interrupt and mret, then mret alone
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        stepCycle();
        pc = 32'h100;
        applyStimulus(1, 4'd3, 1, 0, 1, 0, 0);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        stepCycle();
        stepCycle();
        checkOutput("sim_mcauseDi", oMcauseDi, 32'h3);
        stepCycle();
        checkOutput("sim_pcTarget", oPcTarget, 32'h200);
        stepCycle();
        mepc = 32'h104;
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        stepCycle();
        checkOutput("ret_pcLoad", {31'd0, oPcLoad}, 32'd1);
        checkOutput("ret_pcTarget", oPcTarget, 32'h104);
        stepCycle();
        checkOutput("ret_mie", {31'd0, oMie}, 32'd1);
        checkOutput("ret_mpie", {31'd0, oMpie}, 32'd1);

        // Request held through a busy sequence is taken in the first IDLE cycle
        pc = 32'h300;
        applyStimulus(1, 4'd5, 0, 0, 0, 0, 0);
        stepCycle();
        stepCycle();
        checkOutput("busy_mepcDi", oMepcDi, 32'h300);
        stepCycle();
        checkOutput("busy_mcauseDi", oMcauseDi, 32'h5);
        stepCycle();
        stepCycle();
        checkOutput("busy_reaccept", {31'd0, oFlush}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        repeat (4) stepCycle();

        // Asynchronous reset in the middle of SAVE_CAUSE
        applyStimulus(1, 4'd1, 0, 0, 0, 0, 0);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        stepCycle();
        #2;
        checkOutput("pre_rst_mcauseWe", {31'd0, mcauseWe}, 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("arst_mcauseWe", {31'd0, mcauseWe}, 32'd0);
        checkOutput("arst_mcauseDi", mcauseDi, 32'd0);
        checkOutput("arst_stall", {31'd0, stall}, 32'd0);
        modelReset();
        @(posedge clk); #2;
        reset = 1'b1;
        stepCycle();
        checkOutput("post_rst_mie", {31'd0, oMie}, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if (sched.size() == 0) begin
                pc    = $urandom & 32'hFFFF_FFFC;
                mtvec = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 3));
                mepc  = $urandom & 32'hFFFF_FFFC;
            end
            applyStimulus(($urandom_range(0, 9) == 0), 4'($urandom), ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 5) == 0), ($urandom_range(0, 6) == 0),
                          ($urandom_range(0, 4) == 0), 1'($urandom));
            stepCycle();
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
